regfile_wb_ctrl: RTL and testbench
==================================

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 SHALL have parameter RNONE, default 4'hF: register index meaning "no register / no write".
REQ-002 SHALL have parameter DW, default 64: data width of every value port.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port w_valid_i  input  1  write-back stage presents one instruction's results.
REQ-006 SHALL have port w_ready_o  output  1  block can accept an instruction this cycle.
REQ-007 SHALL have port w_dstE_i  input  4  destination of valE; RNONE means no E write.
REQ-008 SHALL have port w_valE_i  input  DW  ALU result.
REQ-009 SHALL have port w_dstM_i  input  4  destination of valM; RNONE means no M write.
REQ-010 SHALL have port w_valM_i  input  DW  memory result.
REQ-011 SHALL have port reg_we_o  output  1  write strobe to the single register-file write port.
REQ-012 SHALL have port reg_waddr_o  output  4  write index, 0..14.
REQ-013 SHALL have port reg_wdata_o  output  DW  write data.
REQ-014 SHALL have port pend_dst_o  output  4  index of a buffered, not yet issued M write; RNONE if none.
REQ-015 SHALL have port pend_val_o  output  DW  data of the buffered M write; 0 if none.

Function
REQ-016 SHALL serialise each instruction's up to two writes onto the one register-file write port.
REQ-017 SHALL be a two-state FSM: IDLE and WR_M.
REQ-018 SHALL drive w_ready_o = 1 in IDLE and 0 in WR_M, decoded from state only.
REQ-019 SHALL accept an instruction on a rising edge where w_valid_i = 1 and w_ready_o = 1; inputs are ignored otherwise.
REQ-020 SHALL register reg_we_o, reg_waddr_o and reg_wdata_o: the first write of an accepted instruction appears in the cycle after acceptance (latency 1).
REQ-021 SHALL, when exactly one of dstE, dstM is not RNONE, issue that single write next cycle and stay in IDLE.
REQ-022 SHALL, when dstE and dstM are both not RNONE and differ, issue the E write next cycle, buffer dstM/valM, and enter WR_M.
REQ-023 SHALL, in WR_M, issue the buffered M write on the next cycle and return to IDLE; total occupancy is 2 cycles.
REQ-024 SHALL, when dstE = dstM and not RNONE, issue only the M write (valM wins) next cycle and stay in IDLE.
REQ-025 SHALL, when both destinations are RNONE, accept the instruction and issue no write.
REQ-026 SHALL drive reg_we_o = 0, reg_waddr_o = RNONE and reg_wdata_o = 0 in every cycle with no write issued.
REQ-027 SHALL drive pend_dst_o/pend_val_o from the buffer in WR_M, else RNONE/0, so decode forwarding can see the outstanding write.
REQ-028 SHALL never assert reg_we_o with reg_waddr_o = RNONE.

Reset
REQ-029 SHALL, while rst_i = 1, immediately force state IDLE, reg_we_o = 0, reg_waddr_o = RNONE, reg_wdata_o = 0, buffer cleared, pend_dst_o = RNONE, pend_val_o = 0, w_ready_o = 1.
REQ-030 SHALL, on reset asserted in WR_M, discard the buffered M write; it is never issued.
REQ-031 SHALL accept a new instruction on the first rising edge after rst_i deasserts.

Verification
REQ-032 SHALL cover: assert rst_i mid-cycle -> outputs reach reset values without waiting for a clock edge; w_ready_o = 1.
REQ-033 SHALL cover: dstE = 3, valE = 0x10, dstM = RNONE -> next cycle we = 1, waddr = 3, wdata = 0x10; w_ready_o stays 1.
REQ-034 SHALL cover: dstE = 4, valE = 0x100, dstM = 5, valM = 0x200 -> cycle+1 write 4/0x100 with w_ready_o = 0, pend_dst_o = 5; cycle+2 write 5/0x200 with w_ready_o = 1.
REQ-035 SHALL cover: dstE = dstM = 4, valE = 0x1, valM = 0x2 -> one write 4/0x2 only; no second cycle.
REQ-036 SHALL cover: both destinations RNONE, w_valid_i = 1 -> accepted; reg_we_o stays 0.
REQ-037 SHALL cover: REQ-034 stimulus with rst_i pulsed during WR_M -> write 5/0x200 never appears; IDLE after reset.

Source files
------------

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: serialises the up-to-two register writes of each
// retiring instruction (E from the ALU, M from memory) onto a single
// register-file write port. A second write is held in a one-entry buffer
// that is exposed on pend_* so decode can forward from it.
//
// Handshake: an instruction is accepted on a rising edge of clk_i where
// w_valid_i = 1 and w_ready_o = 1. w_ready_o depends on state only and is
// never a function of w_valid_i; inputs in any other cycle are ignored.
module regfile_wb_ctrl #(
  parameter logic [3:0] RNONE = 4'hF,
  parameter int         DW    = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          w_valid_i,
  output logic          w_ready_o,
  input  logic [3:0]    w_dstE_i,
  input  logic [DW-1:0] w_valE_i,
  input  logic [3:0]    w_dstM_i,
  input  logic [DW-1:0] w_valM_i,
  output logic          reg_we_o,
  output logic [3:0]    reg_waddr_o,
  output logic [DW-1:0] reg_wdata_o,
  output logic [3:0]    pend_dst_o,
  output logic [DW-1:0] pend_val_o,
  output logic          dbg_state_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WR_M = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic          r_we;
  logic [3:0]    r_waddr;
  logic [DW-1:0] r_wdata;
  logic [3:0]    r_buf_dst;
  logic [DW-1:0] r_buf_val;

  logic          w_we_n;
  logic [3:0]    w_waddr_n;
  logic [DW-1:0] w_wdata_n;
  logic [3:0]    w_buf_dst_n;
  logic [DW-1:0] w_buf_val_n;

  logic          w_accept;
  logic          w_has_e;
  logic          w_has_m;

  assign w_ready_o = (r_state == S_IDLE);
  assign w_accept  = w_valid_i && w_ready_o;
  assign w_has_e   = (w_dstE_i != RNONE);
  assign w_has_m   = (w_dstM_i != RNONE);

  // Next-state and next-write decode; idle write and empty buffer by default
  always_comb begin
    w_next_state = r_state;
    w_we_n       = 1'b0;
    w_waddr_n    = RNONE;
    w_wdata_n    = '0;
    w_buf_dst_n  = RNONE;
    w_buf_val_n  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_has_e && w_has_m && (w_dstE_i != w_dstM_i)) begin
            // Two distinct targets: E now, M parked for the next cycle
            w_we_n       = 1'b1;
            w_waddr_n    = w_dstE_i;
            w_wdata_n    = w_valE_i;
            w_buf_dst_n  = w_dstM_i;
            w_buf_val_n  = w_valM_i;
            w_next_state = S_WR_M;
          end else if (w_has_m) begin
            // M only, or same target for both: the memory result wins
            w_we_n    = 1'b1;
            w_waddr_n = w_dstM_i;
            w_wdata_n = w_valM_i;
          end else if (w_has_e) begin
            w_we_n    = 1'b1;
            w_waddr_n = w_dstE_i;
            w_wdata_n = w_valE_i;
          end
        end
      end
      S_WR_M: begin
        w_we_n       = 1'b1;
        w_waddr_n    = r_buf_dst;
        w_wdata_n    = r_buf_val;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register; reset drops any parked M write
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Registered write port and pending-write buffer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we      <= 1'b0;
      r_waddr   <= RNONE;
      r_wdata   <= '0;
      r_buf_dst <= RNONE;
      r_buf_val <= '0;
    end else begin
      r_we      <= w_we_n;
      r_waddr   <= w_waddr_n;
      r_wdata   <= w_wdata_n;
      r_buf_dst <= w_buf_dst_n;
      r_buf_val <= w_buf_val_n;
    end
  end

  assign reg_we_o    = r_we;
  assign reg_waddr_o = r_waddr;
  assign reg_wdata_o = r_wdata;
  assign pend_dst_o  = (r_state == S_WR_M) ? r_buf_dst : RNONE;
  assign pend_val_o  = (r_state == S_WR_M) ? r_buf_val : '0;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed vector table, reset corner cases,
// then randomized traffic against a queue-of-pending-writes model.
module tb_regfile_wb_ctrl;
  localparam int         DW = 64;
  localparam logic [3:0] RN = 4'hF;

  logic          clk;
  logic          rst;
  logic          valid;
  logic          ready;
  logic [3:0]    dst_e;
  logic [DW-1:0] val_e;
  logic [3:0]    dst_m;
  logic [DW-1:0] val_m;
  logic          we;
  logic [3:0]    waddr;
  logic [DW-1:0] wdata;
  logic [3:0]    pdst;
  logic [DW-1:0] pval;
  logic          dbg_state;

  int checks = 0;
  int errors = 0;

  regfile_wb_ctrl #(.RNONE(RN), .DW(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .w_valid_i   (valid),
    .w_ready_o   (ready),
    .w_dstE_i    (dst_e),
    .w_valE_i    (val_e),
    .w_dstM_i    (dst_m),
    .w_valM_i    (val_m),
    .reg_we_o    (we),
    .reg_waddr_o (waddr),
    .reg_wdata_o (wdata),
    .pend_dst_o  (pdst),
    .pend_val_o  (pval),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_we, input logic [3:0] e_addr,
                         input logic [DW-1:0] e_data, input logic e_rdy,
                         input logic [3:0] e_pdst, input logic [DW-1:0] e_pval);
    chk({tag, ".we"},    DW'(we),    DW'(e_we));
    chk({tag, ".waddr"}, DW'(waddr), DW'(e_addr));
    chk({tag, ".wdata"}, wdata,      e_data);
    chk({tag, ".ready"}, DW'(ready), DW'(e_rdy));
    chk({tag, ".pdst"},  DW'(pdst),  DW'(e_pdst));
    chk({tag, ".pval"},  pval,       e_pval);
  endtask

  // Driver
  task automatic drive(input logic v, input logic [3:0] de, input logic [DW-1:0] ve,
                       input logic [3:0] dm, input logic [DW-1:0] vm);
    valid = v; dst_e = de; val_e = ve; dst_m = dm; val_m = vm;
  endtask

  typedef struct {
    string         name;
    logic [3:0]    de;
    logic [DW-1:0] ve;
    logic [3:0]    dm;
    logic [DW-1:0] vm;
    logic          c1_we;
    logic [3:0]    c1_addr;
    logic [DW-1:0] c1_data;
    logic          c1_rdy;
    logic [3:0]    c1_pdst;
    logic [DW-1:0] c1_pval;
    logic          c2_we;
    logic [3:0]    c2_addr;
    logic [DW-1:0] c2_data;
  } vec_t;

  vec_t vecs[6];

  // Reference model: writes still owed to the register file, oldest first
  logic [DW+3:0] exp_q[$];

  initial begin
    logic          m_we;
    logic [3:0]    m_addr;
    logic [DW-1:0] m_data;
    logic [DW+3:0] ent;
    logic [3:0]    rde;
    logic [3:0]    rdm;

    vecs[0] = '{"e_only",   4'd3, 64'h10,   RN,    64'hAA,  1, 4'd3,  64'h10,   1, RN,    64'h0,   0, RN,    64'h0};
    vecs[1] = '{"two_wr",   4'd4, 64'h100,  4'd5,  64'h200, 1, 4'd4,  64'h100,  0, 4'd5,  64'h200, 1, 4'd5,  64'h200};
    vecs[2] = '{"same_dst", 4'd4, 64'h1,    4'd4,  64'h2,   1, 4'd4,  64'h2,    1, RN,    64'h0,   0, RN,    64'h0};
    vecs[3] = '{"no_dst",   RN,   64'h33,   RN,    64'h44,  0, RN,    64'h0,    1, RN,    64'h0,   0, RN,    64'h0};
    vecs[4] = '{"m_only",   RN,   64'h99,   4'd14, 64'hDEAD,1, 4'd14, 64'hDEAD, 1, RN,    64'h0,   0, RN,    64'h0};
    vecs[5] = '{"two_edge", 4'd0, 64'h5555, 4'd14, 64'h7,   1, 4'd0,  64'h5555, 0, 4'd14, 64'h7,   1, 4'd14, 64'h7};

    // Power-on reset, checked while still asserted
    rst = 1'b1;
    drive(1'b0, RN, '0, RN, '0);
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, RN, '0, 1, RN, '0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].de, vecs[i].ve, vecs[i].dm, vecs[i].vm);
      @(posedge clk);
      #1;
      drive(1'b0, RN, '0, RN, '0);
      chk_out({vecs[i].name, ".c1"}, vecs[i].c1_we, vecs[i].c1_addr, vecs[i].c1_data,
              vecs[i].c1_rdy, vecs[i].c1_pdst, vecs[i].c1_pval);
      @(posedge clk);
      #1;
      chk_out({vecs[i].name, ".c2"}, vecs[i].c2_we, vecs[i].c2_addr, vecs[i].c2_data,
              1, RN, '0);
    end

    // Valid held during WR_M: the second instruction must wait its turn
    drive(1'b1, 4'd1, 64'hA1, 4'd2, 64'hA2);
    @(posedge clk);
    #1;
    drive(1'b1, 4'd6, 64'hB6, RN, 64'h0);
    chk_out("hold.c1", 1, 4'd1, 64'hA1, 0, 4'd2, 64'hA2);
    @(posedge clk);
    #1;
    chk_out("hold.c2", 1, 4'd2, 64'hA2, 1, RN, '0);
    @(posedge clk);
    #1;
    drive(1'b0, RN, '0, RN, '0);
    chk_out("hold.c3", 1, 4'd6, 64'hB6, 1, RN, '0);

    // Reset pulsed during WR_M drops the buffered M write
    drive(1'b1, 4'd4, 64'h100, 4'd5, 64'h200);
    @(posedge clk);
    #1;
    drive(1'b0, RN, '0, RN, '0);
    chk_out("rstwr.c1", 1, 4'd4, 64'h100, 0, 4'd5, 64'h200);
    #2;
    rst = 1'b1;
    #1;
    chk_out("rstwr.async", 0, RN, '0, 1, RN, '0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 4'd7, 64'h77, RN, 64'h0);
    @(posedge clk);
    #1;
    drive(1'b0, RN, '0, RN, '0);
    chk_out("rstwr.first", 1, 4'd7, 64'h77, 1, RN, '0);
    @(posedge clk);
    #1;
    chk_out("rstwr.after", 0, RN, '0, 1, RN, '0);

    // Randomized traffic against the pending-write queue model
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      rde = ($urandom_range(0, 3) == 0) ? RN : 4'($urandom_range(0, 14));
      rdm = ($urandom_range(0, 3) == 0) ? RN : 4'($urandom_range(0, 14));
      if ($urandom_range(0, 5) == 0) rdm = rde;
      drive(1'($urandom_range(0, 1)), rde, {$urandom, $urandom}, rdm, {$urandom, $urandom});
      @(posedge clk);
      m_we = 1'b0; m_addr = RN; m_data = '0;
      if (exp_q.size() == 0 && valid) begin
        if (dst_e != RN && dst_e == dst_m) begin
          exp_q.push_back({dst_m, val_m});
        end else begin
          if (dst_e != RN) exp_q.push_back({dst_e, val_e});
          if (dst_m != RN) exp_q.push_back({dst_m, val_m});
        end
      end
      if (exp_q.size() > 0) begin
        ent = exp_q.pop_front();
        m_we = 1'b1; m_addr = ent[DW+3:DW]; m_data = ent[DW-1:0];
      end
      #1;
      if (exp_q.size() > 0) begin
        ent = exp_q[0];
        chk_out($sformatf("rand%0d", i), m_we, m_addr, m_data, 0, ent[DW+3:DW], ent[DW-1:0]);
      end else begin
        chk_out($sformatf("rand%0d", i), m_we, m_addr, m_data, 1, RN, '0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
